// File: rtl/spi_shifter_pkg.sv
// Shared types and sizing helpers for the SPI byte shifter and its tick generator.
package spi_shifter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   localparam int HOLD_CNT_W = 4;

   function automatic int bit_cnt_w(input int data_w);
      return (data_w > 1) ? $clog2(data_w) : 1;
   endfunction

endpackage

// File: rtl/spi_byte_shifter_edge_tick.sv
// Registers the divider output and turns its edges into one-clk rise/fall ticks.
module edge_tick (
   input  logic clk,
   input  logic rst_n,
   input  logic freq_in,
   output logic rise_tk,
   output logic fall_tk
);

   logic freq_q;

   // Previous-cycle copy of the divider output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq_q <= 1'b0;
      end else begin
         freq_q <= freq_in;
      end
   end

   assign rise_tk = freq_in & ~freq_q;
   assign fall_tk = ~freq_in & freq_q;

endmodule

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI word transmitter paced by the divider's square wave.
// Optional receive path enabled by defining SPI_BYTE_SHIFTER_RX_EN.
module spi_byte_shifter
   import spi_shifter_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int MSB_FIRST     = 1,
   parameter int CS_HOLD_TICKS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freq_in,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
`ifdef SPI_BYTE_SHIFTER_RX_EN
   input  logic              miso,
   output logic [DATA_W-1:0] rx_data,
`endif
   output logic              in_ready,
   output logic              sclk,
   output logic              mosi,
   output logic              cs_n,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = bit_cnt_w(DATA_W);
   localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(CS_HOLD_TICKS);
   localparam logic [HOLD_CNT_W-1:0] HOLD_ONE  = HOLD_CNT_W'(1);

   logic rise_tk;
   logic fall_tk;

   state_e                  state_q;
   logic [DATA_W-1:0]       sr_q;
   logic [DATA_W-1:0]       sr_d;
   logic [CNT_W-1:0]        bit_cnt_q;
   logic [HOLD_CNT_W-1:0]   hold_cnt_q;
   logic [HOLD_CNT_W-1:0]   hold_cnt_d;
   logic                    first_bit_d;
   logic                    next_bit_d;
   logic                    sclk_q;
   logic                    mosi_q;
   logic                    cs_n_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    in_ready_q;
`ifdef SPI_BYTE_SHIFTER_RX_EN
   logic [DATA_W-1:0]       rx_sr_q;
   logic [DATA_W-1:0]       rx_sr_d;
   logic [DATA_W-1:0]       rx_data_q;
`endif

   edge_tick u_edge_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .freq_in (freq_in),
      .rise_tk (rise_tk),
      .fall_tk (fall_tk)
   );

   // Bit-order dependent shift and the bit that lands on mosi next
   always_comb begin
      sr_d        = sr_q;
      first_bit_d = 1'b0;
      next_bit_d  = 1'b0;
      hold_cnt_d  = hold_cnt_q + HOLD_ONE;
`ifdef SPI_BYTE_SHIFTER_RX_EN
      rx_sr_d     = rx_sr_q;
`endif
      if (MSB_FIRST != 0) begin
         sr_d        = {sr_q[DATA_W-2:0], 1'b0};
         first_bit_d = in_data[DATA_W-1];
         next_bit_d  = sr_q[DATA_W-2];
`ifdef SPI_BYTE_SHIFTER_RX_EN
         rx_sr_d     = {rx_sr_q[DATA_W-2:0], miso};
`endif
      end else begin
         sr_d        = {1'b0, sr_q[DATA_W-1:1]};
         first_bit_d = in_data[0];
         next_bit_d  = sr_q[1];
`ifdef SPI_BYTE_SHIFTER_RX_EN
         rx_sr_d     = {miso, rx_sr_q[DATA_W-1:1]};
`endif
      end
   end

   // Frame sequencer with registered SPI and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         hold_cnt_q <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
`ifdef SPI_BYTE_SHIFTER_RX_EN
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  sr_q       <= in_data;
                  mosi_q     <= first_bit_d;
                  cs_n_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b0;
                  bit_cnt_q  <= '0;
                  state_q    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (fall_tk) begin
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (rise_tk) begin
                  sclk_q <= 1'b1;
`ifdef SPI_BYTE_SHIFTER_RX_EN
                  rx_sr_q <= rx_sr_d;
`endif
               end else if (fall_tk) begin
                  sclk_q <= 1'b0;
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q  <= '0;
                     hold_cnt_q <= '0;
                     state_q    <= ST_HOLD;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_ONE;
                     sr_q      <= sr_d;
                     mosi_q    <= next_bit_d;
                  end
               end
            end
            ST_HOLD: begin
               sclk_q <= 1'b0;
               if (rise_tk) begin
                  hold_cnt_q <= hold_cnt_d;
                  // Leaving on the tick that brings the count to the hold length
                  if (hold_cnt_d == HOLD_LAST) begin
                     cs_n_q  <= 1'b1;
                     done_q  <= 1'b1;
                     mosi_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
`ifdef SPI_BYTE_SHIFTER_RX_EN
                     rx_data_q <= rx_sr_q;
`endif
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;
   assign busy     = busy_q;
   assign done     = done_q;
`ifdef SPI_BYTE_SHIFTER_RX_EN
   assign rx_data  = rx_data_q;
`endif

endmodule

// File: doc/spi_byte_shifter.md
Name: spi_byte_shifter

Overview:
- Serial byte transmitter clocked by the system clock. Sits directly downstream of the clock divider and consumes its divided square wave `freq_in` as a bit-rate reference.
- Converts parallel words from an upstream producer (valid/ready handshake) into a mode-0 SPI frame on `cs_n`/`sclk`/`mosi`.
- `sclk` runs at exactly the `freq_in` frequency. No second clock domain is created.

Parameters:
- DATA_W, 8, word width in bits, legal range 2..16
- MSB_FIRST, 1, 1 = shift MSB first; 0 = LSB first
- CS_HOLD_TICKS, 1, number of `freq_in` rising edges that `cs_n` stays low after the last bit; range 1..15

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- freq_in  in  1  divided clock from the divider; treated as data and edge-detected in `clk`
- in_data  in  DATA_W  word to send
- in_valid  in  1  upstream has a word
- in_ready  out  1  block can accept a word
- sclk  out  1  SPI clock, idle low
- mosi  out  1  serial data
- cs_n  out  1  chip select, active low
- busy  out  1  frame in progress
- done  out  1  one-`clk` pulse at end of frame

Behaviour:
- Edge detection:
  - `freq_q` registers `freq_in`.
  - `rise_tk = freq_in & ~freq_q`; `fall_tk = ~freq_in & freq_q`.
  - Both ticks are one `clk` wide.
- Reset values (asynchronous, immediate, also mid-frame):
  - `sclk=0`, `mosi=0`, `cs_n=1`, `busy=0`, `done=0`.
  - `in_ready=0` while `rst_n` is low, 1 from the first clock after release.
  - State = IDLE, `bit_cnt=0`, `hold_cnt=0`, `freq_q=0`.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - `in_ready=1`, `busy=0`.
  - On `in_valid & in_ready`: latch `in_data` into the shift register, drive `mosi` with the first bit (MSB or LSB per MSB_FIRST), `cs_n<=0`, go to SETUP. All of this happens in the same edge.
- SETUP:
  - Waits for the next `fall_tk`, then goes to SHIFT.
  - Guarantees at least half a `freq_in` period of `cs_n`-to-first-`sclk` setup.
- SHIFT:
  - On `rise_tk`: `sclk<=1`.
  - On `fall_tk`: `sclk<=0`.
    - If `bit_cnt==DATA_W-1`: `bit_cnt<=0`, `hold_cnt<=0`, go to HOLD.
    - Otherwise: `bit_cnt<=bit_cnt+1`, shift, and drive the next bit on `mosi`.
  - `mosi` changes only on falling `sclk`. It is stable at every rising `sclk` (mode 0).
- HOLD:
  - `sclk=0`. `hold_cnt` increments on each `rise_tk`.
  - When `hold_cnt` reaches CS_HOLD_TICKS: `cs_n<=1`, `done<=1` for one cycle, `mosi<=0`, go to IDLE.
- `busy=1` and `in_ready=0` in SETUP, SHIFT and HOLD. `in_valid` during this time is ignored and not queued.
- Back-to-back frames: a word is accepted at the earliest on the cycle after `done`. `cs_n` is always high for at least one `clk` between frames.
- Exactly DATA_W `sclk` rising edges per frame.
- Static `freq_in`: if `freq_in` stops toggling, the FSM holds its state indefinitely. No timeout.
- `rise_tk` and `fall_tk` cannot coincide. The divider guarantees `freq_in` high and low phases of at least 2 `clk`; the bench enforces this.

Optional Feature:
- Macro: SPI_BYTE_SHIFTER_RX_EN.
- Defined:
  - Adds ports `miso` (in, 1) and `rx_data` (out, DATA_W).
  - `miso` is sampled on each `rise_tk` in SHIFT and shifted in using the same bit order as TX.
  - `rx_data` is updated together with the `done` pulse and holds until the next `done`. Reset value 0.
- Undefined: the ports and the RX shift register are absent. TX behaviour is identical in both cases.

Decomposition:
- Package spi_shifter_pkg:
  - state enum (IDLE, SETUP, SHIFT, HOLD)
  - width constant for `bit_cnt`, derived from DATA_W via clog2
  - width constant for `hold_cnt` (4 bits)
- Sub-module edge_tick: registers `freq_in` and produces `rise_tk`/`fall_tk`. Same clock/reset ports as the parent. Reusable by other consumers of the divider.

Test Plan:
- Reset and idle: hold `rst_n` low for 3 clk, then release, with `freq_in` toggling every 10 clk -> `cs_n=1`, `sclk=0`, `busy=0`, `in_ready=1` from the first clk after release.
- Single frame: DATA_W=8, MSB_FIRST=1, send 0xA5 -> exactly 8 `sclk` pulses; `mosi` sampled at `sclk` rising edges = 1,0,1,0,0,1,0,1; `done` is high for 1 clk; `cs_n` rises 1 `freq_in` rising edge after the last `sclk` fall.
- LSB-first: MSB_FIRST=0, send 0x01 -> first sampled bit is 1, remaining 7 bits are 0.
- Back-pressure: hold `in_valid` with 0x3C during a frame carrying 0xFF -> the second word is not accepted until after `done`; the two frames are separated by `cs_n=1` for at least 1 clk.
- Reset mid-frame: assert `rst_n` low after the 4th `sclk` -> `cs_n=1` and `sclk=0` within the same cycle; the next frame, 0x5A, is sent intact.
- RX (macro defined): loop `mosi` back to `miso` and send 0xC3 -> `rx_data=0xC3` at `done`.
